// File: rtl/jk_reg_bank.sv
// jk_reg_bank
//   A bank of WIDTH JK flip-flops that share one rising-edge clock. Each bit
//   has its own active-low synchronous preset and clear. A clock enable and a
//   2-bit mode select choose how the whole bank updates: per-bit JK, toggle
//   under a mask, modulo up/down counter, or parallel load.
//
// Ports
//   clk_i       clock; all state changes on the rising edge
//   rst_i       synchronous active-high reset; overrides every other input
//   en_i        enable for the mode operation (preset/clear ignore it)
//   mode_i      00 JK, 01 toggle, 10 count, 11 load
//   dir_i       count direction, 1 = up, 0 = down (count mode only)
//   j_i         J inputs / toggle mask / load data
//   k_i         K inputs (JK mode only)
//   preset_n_i  per-bit synchronous preset, active-low
//   clear_n_i   per-bit synchronous clear, active-low
//   q_o         register state
//   qn_o        combinational complement of q_o
//   tc_o        one-cycle pulse after an edge where the counter wrapped
//   invalid_o   sticky flag: some bit saw preset and clear asserted together
module jk_reg_bank #(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     RST_VAL = '0,
  parameter logic [WIDTH-1:0]     CNT_MAX = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] j_i,
  input  logic [WIDTH-1:0] k_i,
  input  logic [WIDTH-1:0] preset_n_i,
  input  logic [WIDTH-1:0] clear_n_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qn_o,
  output logic             tc_o,
  output logic             invalid_o
);

  typedef enum logic [1:0] {
    MODE_JK     = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             invalid_q, invalid_d;

  logic [WIDTH-1:0] mode_res;
  logic             wrap;
  mode_e            mode;

  assign mode = mode_e'(mode_i);

  // Full-width result of the selected mode, before the per-bit overrides.
  // The wrap flag is based on this value, so tc_o still pulses when an
  // override changes the bits that are actually stored.
  always_comb begin
    mode_res = q_q;
    wrap     = 1'b0;
    if (en_i) begin
      case (mode)
        // JK characteristic equation: q+ = j & ~q | ~k & q
        MODE_JK:     mode_res = (j_i & ~q_q) | (~k_i & q_q);
        MODE_TOGGLE: mode_res = q_q ^ j_i;
        MODE_COUNT: begin
          // Values above CNT_MAX are treated as out of range. Up wraps
          // them to 0 and down wraps them to CNT_MAX.
          if (dir_i) begin
            if (q_q >= CNT_MAX) begin
              mode_res = '0;
              wrap     = 1'b1;
            end else begin
              mode_res = q_q + WIDTH'(1);
            end
          end else begin
            if (q_q == '0 || q_q > CNT_MAX) begin
              mode_res = CNT_MAX;
              wrap     = 1'b1;
            end else begin
              mode_res = q_q - WIDTH'(1);
            end
          end
        end
        MODE_LOAD:   mode_res = j_i;
        default:     mode_res = q_q;
      endcase
    end
  end

  // Preset wins over clear when both are low. That same combination also
  // sets the sticky invalid flag.
  always_comb begin
    q_d       = ~preset_n_i | (clear_n_i & mode_res);
    tc_d      = wrap;
    invalid_d = invalid_q | (|(~preset_n_i & ~clear_n_i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q       <= RST_VAL;
      tc_q      <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      tc_q      <= tc_d;
      invalid_q <= invalid_d;
    end
  end

  assign q_o       = q_q;
  assign qn_o      = ~q_q;
  assign tc_o      = tc_q;
  assign invalid_o = invalid_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank
//   Directed bench for jk_reg_bank with hand-computed expectations.
//   dut_a : WIDTH=8, RST_VAL=A5, CNT_MAX=FF (general modes, overrides, wrap)
//   dut_b : WIDTH=4, RST_VAL=0,  CNT_MAX=9  (decade counter)
//   dut_c : WIDTH=8, RST_VAL=0,  CNT_MAX=0F (out-of-range count values)
//   All three instances share the same stimulus. dut_b receives the low
//   nibble of the data and override inputs.
module tb_jk_reg_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       dir;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] pn;
  logic [7:0] cn;

  logic [7:0] q_a, qn_a;
  logic       tc_a, inv_a;
  logic [3:0] q_b, qn_b;
  logic       tc_b, inv_b;
  logic [7:0] q_c, qn_c;
  logic       tc_c, inv_c;

  int errors = 0;
  int checks = 0;

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_MAX(8'hFF)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .dir_i(dir),
    .j_i(j), .k_i(k), .preset_n_i(pn), .clear_n_i(cn),
    .q_o(q_a), .qn_o(qn_a), .tc_o(tc_a), .invalid_o(inv_a)
  );

  jk_reg_bank #(.WIDTH(4), .RST_VAL(4'h0), .CNT_MAX(4'd9)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .dir_i(dir),
    .j_i(j[3:0]), .k_i(k[3:0]), .preset_n_i(pn[3:0]), .clear_n_i(cn[3:0]),
    .q_o(q_b), .qn_o(qn_b), .tc_o(tc_b), .invalid_o(inv_b)
  );

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_MAX(8'h0F)) dut_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .dir_i(dir),
    .j_i(j), .k_i(k), .preset_n_i(pn), .clear_n_i(cn),
    .q_o(q_c), .qn_o(qn_c), .tc_o(tc_c), .invalid_o(inv_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs and step through a single rising edge. Outputs
  // are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                               input logic d, input logic [7:0] jv, input logic [7:0] kv,
                               input logic [7:0] pv, input logic [7:0] cv);
    rst  = r;
    en   = e;
    mode = m;
    dir  = d;
    j    = jv;
    k    = kv;
    pn   = pv;
    cn   = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; dir = 1'b0;
    j = '0; k = '0; pn = 8'hFF; cn = 8'hFF;
    #1;

    // Reset
    applyStimulus(1, 1, 2'b11, 0, 8'h00, 8'h00, 8'hFF, 8'hFF);
    checkOutput("rst_q_a",   q_a,   8'hA5);
    checkOutput("rst_qn_a",  qn_a,  8'h5A);
    checkOutput("rst_tc_a",  tc_a,  1'b0);
    checkOutput("rst_inv_a", inv_a, 1'b0);
    checkOutput("rst_q_b",   q_b,   4'h0);

    // JK mode: set, reset, toggle and hold all happen in one vector
    applyStimulus(0, 1, 2'b11, 0, 8'h00, 8'h00, 8'hFF, 8'hFF);
    checkOutput("load_zero", q_a, 8'h00);
    applyStimulus(0, 1, 2'b00, 0, 8'hF0, 8'h3C, 8'hFF, 8'hFF);
    checkOutput("jk_mix",    q_a, 8'hF0);
    checkOutput("jk_qn",     qn_a, 8'h0F);
    applyStimulus(0, 1, 2'b00, 0, 8'h0F, 8'hF0, 8'hFF, 8'hFF);
    checkOutput("jk_swap",   q_a, 8'h0F);
    applyStimulus(0, 1, 2'b00, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    checkOutput("jk_toggle", q_a, 8'hF0);
    applyStimulus(0, 0, 2'b00, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF);
    checkOutput("en_hold",   q_a, 8'hF0);

    // Decade counter on dut_b: 10 up edges, then down from 0
    applyStimulus(1, 0, 2'b00, 0, 8'h00, 8'h00, 8'hFF, 8'hFF);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 1, 2'b10, 1, 8'h00, 8'h00, 8'hFF, 8'hFF);
      checkOutput($sformatf("up_q_%0d", i), q_b, (i % 10));
      checkOutput($sformatf("up_tc_%0d", i), tc_b, (i == 10) ? 1 : 0);
    end
    applyStimulus(0, 1, 2'b10, 0, 8'h00, 8'h00, 8'hFF, 8'hFF);
    checkOutput("down_wrap_q",  q_b,  4'd9);
    checkOutput("down_wrap_tc", tc_b, 1'b1);
    applyStimulus(0, 1, 2'b10, 0, 8'h00, 8'h00, 8'hFF, 8'hFF);
    checkOutput("down_q",  q_b,  4'd8);
    checkOutput("down_tc", tc_b, 1'b0);
    // Reset in the middle of counting
    applyStimulus(1, 1, 2'b10, 0, 8'h00, 8'h00, 8'hFF, 8'hFF);
    checkOutput("mid_rst_q", q_b, 4'd0);

    // Preset and clear with en_i low
    applyStimulus(0, 1, 2'b11, 0, 8'h3C, 8'h00, 8'hFF, 8'hFF);
    checkOutput("load_3c", q_a, 8'h3C);
    applyStimulus(0, 0, 2'b11, 0, 8'h00, 8'h00, 8'hFE, 8'h7F);
    checkOutput("ovr_q",   q_a,   8'h3D);
    checkOutput("ovr_inv", inv_a, 1'b0);
    applyStimulus(0, 0, 2'b11, 0, 8'h00, 8'h00, 8'hFE, 8'hFE);
    checkOutput("both_q",   q_a,   8'h3D);
    checkOutput("both_inv", inv_a, 1'b1);
    applyStimulus(0, 0, 2'b11, 0, 8'h00, 8'h00, 8'hFF, 8'hFF);
    checkOutput("sticky_inv", inv_a, 1'b1);
    applyStimulus(0, 1, 2'b11, 0, 8'h00, 8'h00, 8'hFF, 8'hFF);
    checkOutput("sticky_q",    q_a,   8'h00);
    checkOutput("sticky_inv2", inv_a, 1'b1);

    // Load, toggle, then reset on the same edge as a load
    applyStimulus(0, 1, 2'b11, 0, 8'h3C, 8'h00, 8'hFF, 8'hFF);
    checkOutput("load", q_a, 8'h3C);
    applyStimulus(0, 1, 2'b01, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF);
    checkOutput("toggle", q_a, 8'hC3);
    applyStimulus(1, 1, 2'b11, 0, 8'h77, 8'h00, 8'h00, 8'hFF);
    checkOutput("rst_over_load_q",   q_a,   8'hA5);
    checkOutput("rst_over_load_inv", inv_a, 1'b0);

    // Count wrap combined with an override, and values above CNT_MAX
    applyStimulus(0, 1, 2'b11, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF);
    applyStimulus(0, 1, 2'b10, 1, 8'h00, 8'h00, 8'hFF, 8'hFE);
    checkOutput("ovr_wrap_q_a",  q_a,  8'h00);
    checkOutput("ovr_wrap_tc_a", tc_a, 1'b1);
    checkOutput("over_up_q_c",   q_c,  8'h00);
    checkOutput("over_up_tc_c",  tc_c, 1'b1);
    applyStimulus(0, 1, 2'b11, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF);
    checkOutput("tc_drop", tc_a, 1'b0);
    applyStimulus(0, 1, 2'b10, 0, 8'h00, 8'h00, 8'hFF, 8'hFF);
    checkOutput("down_a_q",      q_a,  8'hFE);
    checkOutput("down_a_tc",     tc_a, 1'b0);
    checkOutput("over_down_q_c", q_c,  8'h0F);
    checkOutput("over_down_tc_c", tc_c, 1'b1);
    applyStimulus(0, 0, 2'b10, 0, 8'h00, 8'h00, 8'hFF, 8'hFF);
    checkOutput("tc_pulse_end", tc_c, 1'b0);
    // A wrap still pulses tc_o when an override forces the stored bit
    applyStimulus(0, 1, 2'b10, 1, 8'h00, 8'h00, 8'hFF, 8'hFF);
    checkOutput("up_wrap_c", q_c, 8'h00);
    applyStimulus(0, 1, 2'b10, 0, 8'h00, 8'h00, 8'hFE, 8'hFF);
    checkOutput("preset_wrap_q_c",  q_c,  8'h0F);
    checkOutput("preset_wrap_tc_c", tc_c, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
